// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle into the register file.
// Loads park in WAIT_LOAD until data arrives or the timeout fires.
module wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_ins,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc4,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wen,
    output logic [4:0]  wadr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOAD,
        WRITE
    } state_t;

    typedef struct packed {
        logic        load;
        logic        wr;
        logic [4:0]  dst;
        logic [2:0]  kind;
        logic [31:0] data;
    } dec_t;

    localparam logic [5:0] OP_RFORM = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [7:0] TO       = TIMEOUT[7:0];

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n, cnt_inc;
    logic        err_n;
    logic        wen_n;
    logic [4:0]  wadr_n;
    logic [31:0] wdata_n;

    logic        ld_wr, ld_wr_n;
    logic [4:0]  ld_dst, ld_dst_n;
    logic [2:0]  ld_kind, ld_kind_n;
    logic [1:0]  ld_off, ld_off_n;

    dec_t        dec;
    logic        accept;
    logic [31:0] ld_data;

    logic unused_bits;
    assign unused_bits = ^{in_ins[25:21], in_ins[10:6]};

    // Loads: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25
    always_comb begin
        logic [5:0] op;
        logic [5:0] fn;
        logic       rform;
        logic       jal;
        logic       imm;
        logic       writer;
        op    = in_ins[31:26];
        fn    = in_ins[5:0];
        rform = (op == OP_RFORM);
        jal   = (op == OP_JAL);
        imm   = (op[5:3] == 3'b001);
        dec.load = (op == 6'h20) || (op == 6'h21) ||
                   (op == 6'h23) || (op == 6'h24) ||
                   (op == 6'h25);
        writer = (rform && fn != FN_JR) || jal || imm || dec.load;
        if (rform)
            dec.dst = in_ins[15:11];
        else if (jal)
            dec.dst = 5'd31;
        else
            dec.dst = in_ins[20:16];
        dec.wr   = writer && (dec.dst != 5'd0);
        dec.kind = op[2:0];
        dec.data = jal ? in_pc4 : in_alu;
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = mem_rdata[{ld_off, 3'b000} +: 8];
        h = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (1'b1)
            ld_kind == 3'b000: ld_data = {{24{b[7]}}, b};
            ld_kind == 3'b001: ld_data = {{16{h[15]}}, h};
            ld_kind == 3'b100: ld_data = {24'd0, b};
            ld_kind == 3'b101: ld_data = {16'd0, h};
            default:           ld_data = mem_rdata;
        endcase
    end

    assign in_ready = (state != WAIT_LOAD);
    assign busy     = (state == WAIT_LOAD);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + 8'd1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        err_n     = err;
        wen_n     = 1'b0;
        wadr_n    = wadr;
        wdata_n   = wdata;
        ld_wr_n   = ld_wr;
        ld_dst_n  = ld_dst;
        ld_kind_n = ld_kind;
        ld_off_n  = ld_off;
        unique case (state)
            WAIT_LOAD: begin
                // data arriving on the last allowed cycle still wins
                if (mem_rvalid) begin
                    state_n = WRITE;
                    wen_n   = ld_wr;
                    if (ld_wr) begin
                        wadr_n  = ld_dst;
                        wdata_n = ld_data;
                    end
                end else if (cnt_inc == TO) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                if (!accept) begin
                    state_n = IDLE;
                end else if (dec.load) begin
                    state_n   = WAIT_LOAD;
                    cnt_n     = 8'd0;
                    ld_wr_n   = dec.wr;
                    ld_dst_n  = dec.dst;
                    ld_kind_n = dec.kind;
                    ld_off_n  = in_alu[1:0];
                end else begin
                    state_n = WRITE;
                    wen_n   = dec.wr;
                    if (dec.wr) begin
                        wadr_n  = dec.dst;
                        wdata_n = dec.data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            err     <= 1'b0;
            wen     <= 1'b0;
            wadr    <= 5'd0;
            wdata   <= 32'd0;
            ld_wr   <= 1'b0;
            ld_dst  <= 5'd0;
            ld_kind <= 3'd0;
            ld_off  <= 2'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            err     <= err_n;
            wen     <= wen_n;
            wadr    <= wadr_n;
            wdata   <= wdata_n;
            ld_wr   <= ld_wr_n;
            ld_dst  <= ld_dst_n;
            ld_kind <= ld_kind_n;
            ld_off  <= ld_off_n;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vectors, expected writes queued in a scoreboard
// and checked by an independent monitor against address, data and cycle.
module tb_wb_stage;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ins;
    logic [31:0] in_alu;
    logic [31:0] in_pc4;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wen;
    logic [4:0]  wadr;
    logic [31:0] wdata;
    logic        busy;
    logic        err;

    wb_stage #(.TIMEOUT(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ins(in_ins),
        .in_alu(in_alu),
        .in_pc4(in_pc4),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .wen(wen),
        .wadr(wadr),
        .wdata(wdata),
        .busy(busy),
        .err(err)
    );

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nmis = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (wen) begin
            nvec++;
            if (sb.size() == 0) begin
                nmis++;
                $display("FAIL unexpected_write cyc=%0d got adr=%0d data=%h",
                         cyc, wadr, wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (wadr !== e.adr || wdata !== e.data || cyc != e.cyc) begin
                    nmis++;
                    $display("FAIL write got (%0d,%h)@%0d want (%0d,%h)@%0d",
                             wadr, wdata, cyc, e.adr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d,
                             input int c);
        exp_t e;
        e.adr  = a;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // drive one instruction for exactly one accepting edge
    task automatic send(input logic [31:0] ins, input logic [31:0] alu,
                        input logic [31:0] pc4, input bit wr,
                        input logic [4:0] a, input logic [31:0] d);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_ins   = ins;
        in_alu   = alu;
        in_pc4   = pc4;
        if (wr) expect_wr(a, d, cyc + 1);
        tick();
        in_valid = 1'b0;
    endtask

    // load whose data shows up on wait cycle dly
    task automatic load(input logic [31:0] ins, input logic [31:0] alu,
                        input int dly, input logic [31:0] rd,
                        input logic [4:0] a, input logic [31:0] d);
        send(ins, alu, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= dly; i++) begin
            chk("busy_wait", {31'd0, busy}, 32'd1);
            chk("ready_low_wait", {31'd0, in_ready}, 32'd0);
            if (i == dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
                expect_wr(a, d, cyc + 1);
            end
            tick();
            mem_rvalid = 1'b0;
        end
        chk("busy_after_load", {31'd0, busy}, 32'd0);
    endtask

    localparam logic [31:0] I_ADDI5  = 32'h20050007;
    localparam logic [31:0] I_ADD9   = {6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] I_JAL    = {6'h03, 26'h0100004};
    localparam logic [31:0] I_JR     = {6'd0, 5'd31, 15'd0, 6'h08};
    localparam logic [31:0] I_SW     = {6'h2B, 5'd29, 5'd8, 16'd0};
    localparam logic [31:0] I_ADDI0  = {6'h08, 5'd3, 5'd0, 16'd1};

    function automatic logic [31:0] ld(input logic [5:0] op,
                                       input logic [4:0] rt);
        return {op, 5'd1, rt, 16'd0};
    endfunction

    initial begin
        RST        = 1'b1;
        in_valid   = 1'b0;
        in_ins     = 32'd0;
        in_alu     = 32'd0;
        in_pc4     = 32'd0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        tick();
        tick();
        RST = 1'b0;
        tick();

        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_wadr", {27'd0, wadr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        send(I_ADDI5, 32'h7, 32'd0, 1'b1, 5'd5, 32'h7);
        send(I_ADD9, 32'hFFFFFFFE, 32'd0, 1'b1, 5'd9, 32'hFFFFFFFE);
        send(I_JAL, 32'h0, 32'h00400010, 1'b1, 5'd31, 32'h00400010);
        send(I_JR, 32'h1234, 32'd0, 1'b0, 5'd0, 32'd0);
        send(I_SW, 32'h1000, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("hold_wadr", {27'd0, wadr}, 32'd31);
        chk("hold_wdata", wdata, 32'h00400010);

        load(ld(6'h20, 5'd4), 32'h1002, 3, 32'h12803456, 5'd4, 32'hFFFFFF80);
        load(ld(6'h24, 5'd4), 32'h1002, 3, 32'h12803456, 5'd4, 32'h00000080);
        load(ld(6'h20, 5'd11), 32'h1003, 1, 32'h12803456, 5'd11, 32'h12);
        load(ld(6'h24, 5'd12), 32'h1001, 2, 32'h12803456, 5'd12, 32'h34);
        load(ld(6'h21, 5'd6), 32'h2002, 1, 32'h80017FFF, 5'd6, 32'hFFFF8001);
        load(ld(6'h25, 5'd7), 32'h2002, 2, 32'h80017FFF, 5'd7, 32'h00008001);
        load(ld(6'h21, 5'd13), 32'h2001, 1, 32'h80017FFF, 5'd13, 32'h7FFF);
        load(ld(6'h23, 5'd8), 32'h2000, 1, 32'h80017FFF, 5'd8, 32'h80017FFF);
        load(ld(6'h23, 5'd14), 32'h2000, 4, 32'hCAFEF00D, 5'd14, 32'hCAFEF00D);
        chk("err_data_wins", {31'd0, err}, 32'd0);
        send(I_ADDI5, 32'h55, 32'd0, 1'b1, 5'd5, 32'h55);

        send(ld(6'h23, 5'd3), 32'h3000, 32'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk("to_busy", {31'd0, busy}, 32'd1);
            chk("to_err_low", {31'd0, err}, 32'd0);
            tick();
        end
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_ready", {31'd0, in_ready}, 32'd1);
        chk("to_busy_off", {31'd0, busy}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rvalid_busy", {31'd0, busy}, 32'd0);
        send(I_ADDI0, 32'h99, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("err_sticky", {31'd0, err}, 32'd1);

        send(ld(6'h23, 5'd10), 32'h4000, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        RST = 1'b1;
        tick();
        chk("mid_rst_wen", {31'd0, wen}, 32'd0);
        chk("mid_rst_wadr", {27'd0, wadr}, 32'd0);
        chk("mid_rst_wdata", wdata, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        RST = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11111111;
        tick();
        mem_rvalid = 1'b0;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        tick();
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
